instr_issue: RTL
================

Name: instr_issue

Overview:
- Transmit side of the 6-bit instruction bus: the producer that serializes decoded instruction fields into the 6-bit word stream the fetch/decode stage consumes.
- Sits in the bench-side and loopback/self-test path, driving the 6-bit input bus of the fetch stage.
- Accepts one full instruction per valid/ready handshake and emits 2 words, or 4 words when the opcode carries an immediate.
- Supports back-to-back frames with no bubble and an output hold.

Parameters:
IMM_MASK, 8'b1000_0000, bit k set means opcode k carries an 8-bit immediate (default: only opcode 3'b111).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
in_valid  input  1  instruction fields valid
in_ready  output  1  block can accept an instruction this cycle
opcode  input  3  instruction opcode
src_a  input  3  source A register
src_b  input  3  source B register
dest  input  3  destination register
imm  input  8  immediate, ignored unless IMM_MASK[opcode]
hold  input  1  freeze current beat; out and out_valid held stable
out  output  6  serialized instruction word
out_valid  output  1  out carries a valid word this cycle
out_sof  output  1  high with word0 of each frame

Behaviour:
- Reset (rst low, async): state IDLE, out=6'b0, out_valid=0, out_sof=0, captured fields cleared. in_ready=1 once rst is released.
- Frame format (registered outputs):
  - W0 = {opcode, src_a}
  - W1 = {src_b, dest}
  - W2 = imm[7:2]
  - W3 = {imm[1:0], 4'b0000}
  - W2 and W3 are sent only if IMM_MASK[opcode].
- Accept: handshake when in_valid && in_ready; all fields are captured that edge. W0 appears on out, with out_valid=1 and out_sof=1, in the cycle after the accept edge (latency 1).
- States and transitions (hold=0):
  - IDLE -> S0 on accept.
  - S0 -> S1.
  - S1 -> S2 if immediate, else frame end.
  - S2 -> S3.
  - S3 -> frame end.
  - At frame end: go to S0 if a new instruction is accepted that same cycle (back-to-back, no gap), else IDLE.
- in_ready = (state==IDLE) || (last beat of frame && !hold). It is combinational from state and hold, never from in_valid.
- hold=1: state, out, out_valid, out_sof and captured fields all frozen. in_ready is low unless in IDLE. In IDLE, hold does not block an accept; W0 is held on out until hold drops.
- out_valid=0 and out=6'b0 in IDLE. out_sof is high only in S0.
- Captured fields are immune to input changes after the accept edge.
- Reset mid-frame: frame aborted immediately, outputs return to reset values, no partial words after release.
- in_valid while not ready: no capture. The producer must hold the fields until accepted.

Decomposition:
- Shared package:
  - state enum (IDLE, S0..S3)
  - opcode constants (OP_LDI = 3'b111)
  - default IMM_MASK
  - word width constant 6
  - pack functions for W0..W3
- One combinational sub-module, instr_pack: selects the beat word from the captured fields plus beat index, and reports has_imm. Reused by the bench's reference model.

Test Plan:
- Plain instruction: opcode=3'b010, src_a=3'b101, src_b=3'b001, dest=3'b110 accepted at cycle 0 -> cycle 1 out=0x15, sof=1; cycle 2 out=0x0E, sof=0; cycle 3 out_valid=0, in_ready=1.
- Immediate instruction: opcode=3'b111, src_a=0, src_b=0, dest=3'b010, imm=0xA7 -> out words 0x38, 0x02, 0x29, 0x30 on 4 consecutive cycles, sof only on the first.
- Back-to-back: in_valid held high with two plain instructions -> second W0 immediately follows first W1. No idle cycle, in_ready high only on the W1 cycles.
- Hold: assert hold for 3 cycles during W1 of an immediate frame -> out stays 0x0E with out_valid=1 for 4 cycles total. in_ready stays low. Sequence resumes with 0x29, 0x30.
- Reset mid-frame: drive rst low during W2 -> out=0, out_valid=0 asynchronously. After release, in_ready=1 and no W3 is emitted.
- Input stability: change the opcode and imm inputs the cycle after accept -> emitted words still reflect the captured values.

Source files
------------

// File: rtl/instr_issue_pkg.sv
// -----------------------------------------------------------------------------
// instr_issue_pkg
// Shared definitions for the 6-bit instruction bus transmitter:
//   - word width and opcode constants
//   - default immediate mask (which opcodes carry an 8-bit immediate)
//   - FSM state enumeration
//   - captured instruction record
//   - pack helpers that build the four frame words
// -----------------------------------------------------------------------------
package instr_issue_pkg;

    localparam int WORD_W = 6;

    localparam logic [2:0] OP_LDI = 3'b111;

    // Only OP_LDI carries an immediate unless the instantiation overrides it.
    localparam logic [7:0] DEF_IMM_MASK = 8'b1 << OP_LDI;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] src_a;
        logic [2:0] src_b;
        logic [2:0] dest;
        logic [7:0] imm;
    } instr_t;

    function automatic logic [WORD_W-1:0] pack_w0(input instr_t f);
        return {f.opcode, f.src_a};
    endfunction

    function automatic logic [WORD_W-1:0] pack_w1(input instr_t f);
        return {f.src_b, f.dest};
    endfunction

    function automatic logic [WORD_W-1:0] pack_w2(input instr_t f);
        return f.imm[7:2];
    endfunction

    function automatic logic [WORD_W-1:0] pack_w3(input instr_t f);
        return {f.imm[1:0], 4'b0000};
    endfunction

    function automatic logic [WORD_W-1:0] pack_word(input instr_t f, input logic [1:0] beat);
        logic [WORD_W-1:0] w;
        case (beat)
            2'd0:    w = pack_w0(f);
            2'd1:    w = pack_w1(f);
            2'd2:    w = pack_w2(f);
            default: w = pack_w3(f);
        endcase
        return w;
    endfunction

    function automatic logic op_has_imm(input logic [7:0] mask, input logic [2:0] op);
        return mask[op];
    endfunction

endpackage

// File: rtl/instr_issue_if.sv
// -----------------------------------------------------------------------------
// instr_issue_if
// Bundles the instruction-side handshake and the serialized word stream of
// the 6-bit instruction bus transmitter.
//   in_valid/in_ready        : one instruction per handshake
//   opcode/src_a/src_b/dest  : decoded instruction fields
//   imm                      : 8-bit immediate (used only by immediate opcodes)
//   hold                     : freezes the current beat
//   out/out_valid/out_sof    : serialized word, valid flag, start-of-frame
// master = producer/consumer side (bench), slave = the transmitter block.
// -----------------------------------------------------------------------------
interface instr_issue_if
    import instr_issue_pkg::*;
;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        opcode;
    logic [2:0]        src_a;
    logic [2:0]        src_b;
    logic [2:0]        dest;
    logic [7:0]        imm;
    logic              hold;
    logic [WORD_W-1:0] out;
    logic              out_valid;
    logic              out_sof;

    modport master (
        output in_valid, opcode, src_a, src_b, dest, imm, hold,
        input  in_ready, out, out_valid, out_sof
    );

    modport slave (
        input  in_valid, opcode, src_a, src_b, dest, imm, hold,
        output in_ready, out, out_valid, out_sof
    );

endinterface

// File: rtl/instr_issue_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Combinational word selector: given captured instruction fields and a beat
// index (0..3) returns the corresponding frame word, and reports whether the
// opcode carries an immediate (i.e. whether beats 2 and 3 exist).
// Ports:
//   fld     : captured instruction fields
//   beat    : beat index within the frame
//   word    : selected 6-bit word
//   has_imm : IMM_MASK[fld.opcode]
// -----------------------------------------------------------------------------
module instr_pack
    import instr_issue_pkg::*;
#(
    parameter logic [7:0] IMM_MASK = DEF_IMM_MASK
) (
    input  instr_t            fld,
    input  logic [1:0]        beat,
    output logic [WORD_W-1:0] word,
    output logic              has_imm
);

    always_comb begin
        word    = pack_word(fld, beat);
        has_imm = op_has_imm(IMM_MASK, fld.opcode);
    end

endmodule

// File: rtl/instr_issue.sv
// -----------------------------------------------------------------------------
// instr_issue
// Transmit side of the 6-bit instruction bus. Accepts one decoded
// instruction per valid/ready handshake and serializes it as 2 words, or 4
// words when the opcode carries an immediate:
//   W0 = {opcode, src_a}   W1 = {src_b, dest}
//   W2 = imm[7:2]          W3 = {imm[1:0], 4'b0000}
// Outputs are registered; W0 appears the cycle after the accept edge.
// A new instruction may be accepted on the last beat of a frame so frames
// run back to back. hold freezes the current beat (not in IDLE).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   bus  : instr_issue_if.slave (handshake, fields, hold, word stream)
// -----------------------------------------------------------------------------
module instr_issue
    import instr_issue_pkg::*;
#(
    parameter logic [7:0] IMM_MASK = DEF_IMM_MASK
) (
    input  logic          clk,
    input  logic          rst,
    instr_issue_if.slave  bus
);

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_S0   = S0;
    localparam logic [2:0] ST_S1   = S1;
    localparam logic [2:0] ST_S2   = S2;
    localparam logic [2:0] ST_S3   = S3;

    logic [2:0]        state_q, state_d;
    instr_t            fld_q, fld_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sof_q, out_sof_d;

    instr_t            new_fld;
    logic [1:0]        beat_nxt;
    logic [WORD_W-1:0] word_nxt;
    logic              has_imm;
    logic              last_beat;
    logic              frozen;
    logic              in_ready;
    logic              accept;

    // Beat index of the word that follows the one currently on out,
    // for a frame that continues (no new accept).
    always_comb begin
        case (state_q)
            ST_S0:   beat_nxt = 2'd1;
            ST_S1:   beat_nxt = 2'd2;
            ST_S2:   beat_nxt = 2'd3;
            default: beat_nxt = 2'd0;
        endcase
    end

    instr_pack #(
        .IMM_MASK (IMM_MASK)
    ) u_pack (
        .fld     (fld_q),
        .beat    (beat_nxt),
        .word    (word_nxt),
        .has_imm (has_imm)
    );

    always_comb begin
        new_fld.opcode = bus.opcode;
        new_fld.src_a  = bus.src_a;
        new_fld.src_b  = bus.src_b;
        new_fld.dest   = bus.dest;
        new_fld.imm    = bus.imm;
    end

    // Ready depends only on state and hold so the producer never sees a
    // combinational path from its own in_valid.
    always_comb begin
        last_beat = ((state_q == ST_S1) && !has_imm) || (state_q == ST_S3);
        in_ready  = (state_q == ST_IDLE) || (last_beat && !bus.hold);
        accept    = bus.in_valid && in_ready;
        frozen    = bus.hold && (state_q != ST_IDLE);
    end

    always_comb begin
        state_d     = state_q;
        fld_d       = fld_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;

        if (!frozen) begin
            case (state_q)
                ST_IDLE: state_d = accept ? ST_S0 : ST_IDLE;
                ST_S0:   state_d = ST_S1;
                ST_S1:   state_d = has_imm ? ST_S2 : (accept ? ST_S0 : ST_IDLE);
                ST_S2:   state_d = ST_S3;
                ST_S3:   state_d = accept ? ST_S0 : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase

            // A fresh accept always starts a new frame with W0 taken
            // straight from the bus fields being captured this edge.
            if (accept) begin
                fld_d       = new_fld;
                out_d       = pack_w0(new_fld);
                out_valid_d = 1'b1;
                out_sof_d   = 1'b1;
            end else if (state_d != ST_IDLE) begin
                out_d       = word_nxt;
                out_valid_d = 1'b1;
                out_sof_d   = 1'b0;
            end else begin
                out_d       = '0;
                out_valid_d = 1'b0;
                out_sof_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fld_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fld_q       <= fld_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;

endmodule
